// File: rtl/mem_bus_arbiter_if.sv
// Bus-request/grant bundle shared by the arbiter and the masters it serves.
// The arbiter connects through the slave modport; requesters use master.
interface mem_bus_arbiter_if;
  logic [3:0] req;
  logic       bus_busy;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       owner_valid;
  logic       timeout_err;

  modport master (
    output req, bus_busy,
    input  grant, owner, owner_valid, timeout_err
  );

  modport slave (
    input  req, bus_busy,
    output grant, owner, owner_valid, timeout_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for four bus masters sharing a tristate memory bus.
// Registered grant, unaccepted-grant timeout, and one turnaround cycle between owners.
module mem_bus_arbiter #(
  parameter int unsigned GRANT_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_OWNED,
    S_FOREIGN,
    S_TURN
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(GRANT_TIMEOUT - 1);

  state_t     r_state, w_state;
  logic [1:0] r_ptr, w_ptr;
  logic [3:0] r_cnt, w_cnt;
  logic [3:0] r_grant, w_grant;
  logic [1:0] r_owner, w_owner;
  logic       r_owner_valid, w_owner_valid;
  logic       r_timeout_err, w_timeout_err;

  logic [1:0] w_sel;
  logic       w_sel_valid;

  // Scan from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    w_sel       = r_ptr;
    w_sel_valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[r_ptr + 2'(i)]) begin
        w_sel       = r_ptr + 2'(i);
        w_sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no path leaves it unassigned; otherwise a latch is inferred.
    w_state       = r_state;
    w_ptr         = r_ptr;
    w_cnt         = r_cnt;
    w_grant       = 4'b0000;
    w_owner       = r_owner;
    w_owner_valid = 1'b0;
    w_timeout_err = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.bus_busy) begin
          w_state = S_FOREIGN;
        end else if (w_sel_valid) begin
          w_state = S_GRANT;
          w_owner = w_sel;
          w_grant = 4'b0001 << w_sel;
          w_cnt   = 4'd0;
        end
      end

      S_GRANT: begin
        // Acceptance outranks both a withdrawn request and an expiring timer.
        if (bus.bus_busy) begin
          w_state       = S_OWNED;
          w_owner_valid = 1'b1;
        end else if (!bus.req[r_owner]) begin
          w_state = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state       = S_IDLE;
          w_timeout_err = 1'b1;
          w_ptr         = r_owner + 2'd1;
        end else begin
          w_grant = r_grant;
          w_cnt   = r_cnt + 4'd1;
        end
      end

      S_OWNED: begin
        if (!bus.bus_busy) begin
          w_state = S_TURN;
          w_ptr   = r_owner + 2'd1;
        end else begin
          w_owner_valid = 1'b1;
        end
      end

      S_FOREIGN: begin
        if (!bus.bus_busy) w_state = S_TURN;
      end

      S_TURN: w_state = S_IDLE;

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= 2'd0;
      r_cnt         <= 4'd0;
      r_grant       <= 4'b0000;
      r_owner       <= 2'd0;
      r_owner_valid <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_ptr         <= w_ptr;
      r_cnt         <= w_cnt;
      r_grant       <= w_grant;
      r_owner       <= w_owner;
      r_owner_valid <= w_owner_valid;
      r_timeout_err <= w_timeout_err;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.owner       = r_owner;
  assign bus.owner_valid = r_owner_valid;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter GRANT_TIMEOUT, default 8, meaning cycles a grant may remain unaccepted before revocation (legal range 2-15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  4  per-requester bus request (bit 0 icache, bit 1 dcache, bits 2-3 spare masters).
REQ-005 SHALL have port bus_busy  input  1  wired-OR of all masters' busy outputs; high while any master owns the bus.
REQ-006 SHALL have port grant  output  4  one-hot (or zero) grant to requesters.
REQ-007 SHALL have port owner  output  2  index of last granted requester.
REQ-008 SHALL have port owner_valid  output  1  high while granted requester owns the bus.
REQ-009 SHALL have port timeout_err  output  1  one-cycle pulse when a grant is revoked unaccepted.

Function
REQ-010 SHALL implement states IDLE, GRANT, OWNED, FOREIGN, TURN.
REQ-011 SHALL keep a 2-bit round-robin pointer ptr; priority order ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-012 IDLE, bus_busy=1: SHALL go to FOREIGN, no grant issued.
REQ-013 IDLE, bus_busy=0, req!=0: SHALL select the highest-priority asserted bit, register owner, drive that grant bit from next cycle, go to GRANT.
REQ-014 IDLE, req=0, bus_busy=0: SHALL remain IDLE, grant=0.
REQ-015 grant SHALL be a registered output, never combinational from req.
REQ-016 GRANT: grant[owner] held high; 4-bit wait counter cleared on entry, incremented each cycle.
REQ-017 GRANT, bus_busy=1: SHALL drop grant next cycle, set owner_valid, go to OWNED.
REQ-018 GRANT, bus_busy=0, req[owner]=0: SHALL drop grant, go to IDLE; ptr unchanged.
REQ-019 GRANT, counter reaches GRANT_TIMEOUT-1 without bus_busy: SHALL drop grant, pulse timeout_err one cycle, set ptr=owner+1 mod 4, go to IDLE.
REQ-020 If bus_busy and timeout coincide in the same cycle, bus_busy SHALL win (OWNED, no timeout_err).
REQ-021 OWNED: grant=0, owner_valid=1; bus_busy falling (sampled 0) SHALL clear owner_valid, set ptr=owner+1 mod 4, go to TURN.
REQ-022 TURN: one dead cycle, grant=0, no new decision; then IDLE (bus turnaround for tristate drivers).
REQ-023 FOREIGN: grant=0, owner_valid=0; bus_busy=0 SHALL go to TURN; ptr unchanged.
REQ-024 At most one grant bit SHALL be high in any cycle; grant SHALL never be high while bus_busy was sampled high in the same state.
REQ-025 Minimum request-to-grant latency SHALL be 1 cycle from IDLE; back-to-back ownership SHALL have at least 2 idle-grant cycles (TURN + IDLE).
REQ-026 ptr wrap: owner=3 SHALL set ptr=0.
REQ-027 req changes while in OWNED/TURN/FOREIGN SHALL be ignored until IDLE.

Reset
REQ-028 reset high SHALL force state IDLE, ptr=0, counter=0, grant=0, owner=0, owner_valid=0, timeout_err=0 on the next edge, overriding any state including OWNED mid-transfer.
REQ-029 First post-reset arbitration SHALL favour req[0].

Verification
REQ-030 Reset, then req=4'b0110 -> next cycle grant=4'b0010, owner=1.
REQ-031 Grant to 1, bus_busy high 3 cycles then low, req=4'b0011 held -> grant drops after busy, owner_valid high 3 cycles, TURN, IDLE, then grant=4'b0001 (ptr=2 wraps to 0 since bits 2,3 idle); next round grants 1 again (round-robin fairness).
REQ-032 req=4'b1000, never assert bus_busy -> grant=4'b1000 for exactly 8 cycles, timeout_err one pulse, ptr=0, re-grant to 3 only after IDLE.
REQ-033 bus_busy high in IDLE with req=4'b0001 -> FOREIGN, grant stays 0 until busy drops plus TURN, then grant=4'b0001.
REQ-034 reset asserted during OWNED -> next cycle all outputs 0, state IDLE.
REQ-035 Randomized req/bus_busy 10k cycles -> grant one-hot-or-zero always; no requester starved beyond 3 other ownerships.
